// File: rtl/note_player_ctrl.sv
// Responder for the new_note/note_done handshake: latches a note, times it in
// beats of BEAT_DIV clocks and drives the tone generator enable.
module note_player_ctrl #(
    parameter int unsigned BEAT_DIV = 1000,
    parameter int unsigned NOTE_W   = 6,
    parameter int unsigned DUR_W    = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              new_note,
    input  logic [NOTE_W-1:0] note,
    input  logic [DUR_W-1:0]  duration,
    output logic              note_done,
    output logic [NOTE_W-1:0] cur_note,
    output logic              tone_en,
    output logic              busy
);
    localparam int unsigned       CNT_W    = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BEAT_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [DUR_W-1:0]  ONE_BEAT = DUR_W'(1);

    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] beat_cnt;
    logic [DUR_W-1:0] remaining;
    logic             load;
    logic             zero_dur;

    assign load     = new_note && play;
    assign zero_dur = (duration == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            note_done <= 1'b0;
            cur_note  <= '0;
            tone_en   <= 1'b0;
            busy      <= 1'b0;
            remaining <= '0;
            beat_cnt  <= '0;
        end else begin
            note_done <= 1'b0;
            if (load) begin
                cur_note <= note;
                beat_cnt <= '0;
                busy     <= 1'b1;
                // A zero-length note arriving while already in DONE is timed as
                // one beat so note_done can never pulse on two consecutive cycles.
                if (zero_dur && state != DONE) begin
                    state     <= DONE;
                    note_done <= 1'b1;
                    remaining <= '0;
                    tone_en   <= 1'b0;
                end else begin
                    state     <= PLAY;
                    remaining <= zero_dur ? ONE_BEAT : duration;
                    tone_en   <= (note != '0);
                end
            end else begin
                case (state)
                    IDLE: begin
                        tone_en <= 1'b0;
                        busy    <= 1'b0;
                    end
                    PLAY: begin
                        if (!play) begin
                            tone_en <= 1'b0;
                        end else if (beat_cnt == LAST_CNT) begin
                            beat_cnt <= '0;
                            if (remaining == ONE_BEAT) begin
                                state     <= DONE;
                                note_done <= 1'b1;
                                tone_en   <= 1'b0;
                            end else begin
                                remaining <= remaining - ONE_BEAT;
                                tone_en   <= (cur_note != '0);
                            end
                        end else begin
                            beat_cnt <= beat_cnt + CNT_ONE;
                            tone_en  <= (cur_note != '0);
                        end
                    end
                    DONE: begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        tone_en <= 1'b0;
                    end
                    default: begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        tone_en <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_note_player_ctrl.sv
// Directed self-checking bench for note_player_ctrl with BEAT_DIV=4.
module tb_note_player_ctrl;
    logic       clk;
    logic       reset;
    logic       play;
    logic       new_note;
    logic [5:0] note;
    logic [5:0] duration;
    logic       note_done;
    logic [5:0] cur_note;
    logic       tone_en;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int pulse_cnt = 0;

    note_player_ctrl #(.BEAT_DIV(4), .NOTE_W(6), .DUR_W(6)) dut (
        .clk(clk), .reset(reset), .play(play), .new_note(new_note),
        .note(note), .duration(duration), .note_done(note_done),
        .cur_note(cur_note), .tone_en(tone_en), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (note_done) pulse_cnt++;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n, input int d);
        new_note = 1'b1;
        note     = 6'(n);
        duration = 6'(d);
        tick();
        new_note = 1'b0;
    endtask

    // lat = cycles after the load edge at which note_done is seen, -1 on timeout
    task automatic wait_done(input int limit, output int lat, output int tone_seen);
        lat = -1;
        tone_seen = 0;
        for (int c = 0; c <= limit; c++) begin
            if (tone_en) tone_seen = 1;
            if (note_done) begin
                lat = c;
                break;
            end
            tick();
        end
    endtask

    int durs[20] = '{1, 2, 3, 1, 2, 1, 3, 2, 1, 1, 2, 3, 1, 2, 1, 2, 3, 1, 1, 2};

    initial begin
        int lat;
        int ts;
        int p0;
        int early;

        reset = 1'b1; play = 1'b1; new_note = 1'b0; note = '0; duration = '0;

        // 1) reset, then note 5 for 3 beats
        tick(); tick();
        check("rst_done", int'(note_done), 0);
        check("rst_note", int'(cur_note), 0);
        check("rst_tone", int'(tone_en), 0);
        check("rst_busy", int'(busy), 0);
        reset = 1'b0;
        tick();
        load(5, 3);
        check("t1_note", int'(cur_note), 5);
        check("t1_tone", int'(tone_en), 1);
        check("t1_busy", int'(busy), 1);
        wait_done(20, lat, ts);
        check("t1_lat", lat, 12);
        tick();
        check("t1_done_clr", int'(note_done), 0);
        check("t1_idle", int'(busy), 0);
        check("t1_tone_off", int'(tone_en), 0);

        // new_note while paused is ignored
        play = 1'b0;
        load(11, 2);
        check("ign_busy", int'(busy), 0);
        check("ign_done", int'(note_done), 0);
        play = 1'b1;
        tick();

        // 2) zero-length note
        load(9, 0);
        wait_done(5, lat, ts);
        check("t2_lat", lat, 0);
        check("t2_tone", ts, 0);
        tick();
        check("t2_done_clr", int'(note_done), 0);
        check("t2_idle", int'(busy), 0);

        // 3) rest for 2 beats
        load(0, 2);
        wait_done(20, lat, ts);
        check("t3_lat", lat, 8);
        check("t3_tone", ts, 0);
        tick();

        // 4) pause for 5 cycles mid-note
        load(3, 2);
        tick(); tick(); tick();
        check("t4_tone_run", int'(tone_en), 1);
        play = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_tone_pause", int'(tone_en), 0);
            check("t4_done_pause", int'(note_done), 0);
        end
        play = 1'b1;
        wait_done(20, lat, ts);
        check("t4_lat", lat >= 0 ? lat + 8 : -1, 13);
        tick();

        // 5) restart with note 7 six cycles into a 4-beat note
        p0 = pulse_cnt;
        load(4, 4);
        for (int i = 0; i < 5; i++) tick();
        load(7, 1);
        check("t5_note", int'(cur_note), 7);
        wait_done(20, lat, ts);
        check("t5_lat", lat, 4);
        for (int i = 0; i < 16; i++) tick();
        check("t5_pulses", pulse_cnt - p0, 1);

        // restart coinciding with the final tick: new note wins
        load(2, 1);
        tick(); tick(); tick();
        load(4, 1);
        check("fin_suppress", int'(note_done), 0);
        check("fin_note", int'(cur_note), 4);
        wait_done(20, lat, ts);
        check("fin_lat", lat, 4);
        tick();

        // 6) reset three cycles into a 2-beat note
        p0 = pulse_cnt;
        load(6, 2);
        tick(); tick(); tick();
        reset = 1'b1;
        tick();
        check("t6_note", int'(cur_note), 0);
        check("t6_tone", int'(tone_en), 0);
        check("t6_busy", int'(busy), 0);
        check("t6_done", int'(note_done), 0);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("t6_pulses", pulse_cnt - p0, 0);

        // back-to-back song: each note_done triggers the next new_note
        p0 = pulse_cnt;
        early = 0;
        for (int i = 0; i < 20; i++) begin
            load(i + 1, durs[i]);
            if (note_done) early++;
            wait_done(40, lat, ts);
            check("song_lat", lat, durs[i] * 4);
        end
        tick();
        check("song_idle", int'(busy), 0);
        for (int i = 0; i < 10; i++) tick();
        check("song_pulses", pulse_cnt - p0, 20);
        check("song_early", early, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
